datapath_seq: RTL and testbench
===============================

// Module: datapath_seq
// PURPOSE
//  Parametrised successor to the 16-bit RISC datapath. Holds a W-bit, NREG-entry register file,
//  A/B operand registers, shifter, ALU, C result register and Z/V/N status flags. Adds an internal
//  sequencer: one start/ready handshake runs a full read-A, read-B, execute, writeback operation,
//  so the controller no longer drives loada/loadb/loadc/write cycle by cycle.
//  Sits between the instruction decoder/FSM controller and memory/PC logic.
// PARAMETERS
//  W      16  datapath width (>=4)
//  NREG   8   register-file entries (power of 2)
//  RW     3   register index width, log2(NREG)
//  PCW    8   PC width, zero-extended to W on writeback (PCW<=W)
// PORTS
//  clk      in   1    clock, all state on rising edge
//  reset    in   1    synchronous, active-high
//  start    in   1    request; accepted when start && ready
//  ready    out  1    idle, can accept start
//  done     out  1    one-cycle pulse in WB state
//  err      out  1    sticky; set on invalid vsel at WB; cleared by reset or accepted start
//  rn       in   RW   A-operand register index
//  rm       in   RW   B-operand register index
//  rd       in   RW   writeback register index
//  shift    in   2    00 none, 01 <<1, 10 >>1 logical, 11 >>1 arithmetic (applied to B)
//  aluop    in   2    00 A+B, 01 A-B, 10 A&B, 11 ~B
//  asel     in   1    1: Ain=0; 0: Ain=A
//  bsel     in   1    1: Bin=sximm5; 0: Bin=shifted B
//  loads    in   1    update Z/V/N in EXEC
//  wb_en    in   1    1: write rd in WB; 0: compare-only
//  vsel     in   4    one-hot writeback source: 1000 mdata, 0100 sximm8, 0010 {0,PC}, 0001 C
//  mdata    in   W    memory data
//  sximm8   in   W    sign-extended 8-bit immediate
//  sximm5   in   W    sign-extended 5-bit immediate
//  PC       in   PCW  program counter
//  C        out  W    result register
//  Zout     out  1    zero flag
//  Vout     out  1    signed overflow flag
//  Nout     out  1    negative flag (MSB of ALU out)
// BEHAVIOUR
//  - Reset: all regfile entries, A, B, C = 0; Zout=Vout=Nout=0; err=0; done=0; state IDLE; ready=1.
//  - Control fields (rn..vsel) and sximm5/sximm8 are captured on the accepting edge; changes
//    afterwards are ignored. mdata and PC are sampled live in WB.
//  - FSM: IDLE -(start)-> LOADA -> LOADB -> EXEC -> WB -> IDLE. ready=1 only in IDLE.
//    LOADA: A<=R[rn]. LOADB: B<=R[rm]. EXEC: C<=ALU(Ain,Bin); if loads, flags<=Z,V,N.
//    WB: done=1; if wb_en and vsel one-hot, R[rd]<=selected source at end of cycle.
//  - Latency: start accepted at edge t -> done high in cycle t+4 -> ready again at t+5.
//    One op per 5 cycles, no overlap.
//  - start while busy: ignored (no queuing). start held high in IDLE: back-to-back ops.
//  - Arithmetic: modulo 2^W. Z = (out==0). N = out[W-1]. V: add = operands same sign and result
//    sign differs; sub = operands differ in sign and result sign != A sign; V=0 for AND/NOT.
//  - Invalid vsel (not one-hot) at WB with wb_en=1: no write, err<=1, done still pulses.
//  - Flags and C hold when not written. PC zero-extended to W.
//  - Regfile reads are combinational from current contents, so an op whose rn/rm equals the
//    previous op's rd sees the written value.
//  - Reset mid-operation: abort, no writeback, return to reset state next cycle.
// TESTING
//  1. Reset, start vsel=0100 sximm8=5 rd=1 wb_en=1 -> done at t+4, R1=5, ready at t+5.
//  2. R1=5, R2=3; ADD rd=3 rn=1 rm=2 shift=01 vsel=0001 loads=1 -> C=11 (0x000B), R3=11, Z=V=N=0.
//  3. SUB rn=2 rm=2 wb_en=0 loads=1 -> C=0, Zout=1, registers unchanged.
//  4. R1=0x7FFF, R2=1; ADD loads=1 -> C=0x8000, Vout=1, Nout=1; AND same regs -> Vout=0.
//  5. vsel=0110 wb_en=1 -> err=1, no write, done pulses; next accepted start clears err.
//  6. reset asserted during EXEC -> no write to rd, all regs/flags 0, ready=1 after reset;
//     start during LOADB ignored.

Source files
------------

// File: rtl/datapath_seq_if.sv
// Handshake and operand bus between the controller and the sequenced datapath.
interface datapath_seq_if #(
    parameter int W   = 16,
    parameter int RW  = 3,
    parameter int PCW = 8
) ();
    logic           start;
    logic           ready;
    logic           done;
    logic           err;
    logic [RW-1:0]  rn;
    logic [RW-1:0]  rm;
    logic [RW-1:0]  rd;
    logic [1:0]     shift;
    logic [1:0]     aluop;
    logic           asel;
    logic           bsel;
    logic           loads;
    logic           wb_en;
    logic [3:0]     vsel;
    logic [W-1:0]   mdata;
    logic [W-1:0]   sximm8;
    logic [W-1:0]   sximm5;
    logic [PCW-1:0] PC;
    logic [W-1:0]   C;
    logic           Zout;
    logic           Vout;
    logic           Nout;

    modport master (
        output start, rn, rm, rd, shift, aluop, asel, bsel, loads, wb_en, vsel,
               mdata, sximm8, sximm5, PC,
        input  ready, done, err, C, Zout, Vout, Nout
    );

    modport slave (
        input  start, rn, rm, rd, shift, aluop, asel, bsel, loads, wb_en, vsel,
               mdata, sximm8, sximm5, PC,
        output ready, done, err, C, Zout, Vout, Nout
    );
endinterface

// File: rtl/datapath_seq.sv
// Parametrised RISC datapath with an internal read-A / read-B / execute / writeback sequencer
// driven by a single start/ready handshake.
module datapath_seq #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int RW   = 3,
    parameter int PCW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    datapath_seq_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADA = 3'd1,
        ST_LOADB = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    state_t         state_r;
    logic [W-1:0]   regs_r [NREG];
    logic [W-1:0]   a_r, b_r, c_r;
    logic           z_r, v_r, n_r;
    logic           ready_r, done_r, err_r;
    logic [RW-1:0]  rn_r, rm_r, rd_r;
    logic [1:0]     shift_r, aluop_r;
    logic           asel_r, bsel_r, loads_r, wb_en_r;
    logic [3:0]     vsel_r;
    logic [W-1:0]   sximm8_r, sximm5_r;

    logic [W-1:0]   ain_s, bsh_s, bin_s, alu_s, pc_ext_s, wb_data_s;
    logic           ovf_s;

    // Shifter on B, operand muxes and ALU with signed-overflow detection.
    always_comb begin
        ain_s = asel_r ? {W{1'b0}} : a_r;
        case (shift_r)
            2'b00:   bsh_s = b_r;
            2'b01:   bsh_s = {b_r[W-2:0], 1'b0};
            2'b10:   bsh_s = {1'b0, b_r[W-1:1]};
            2'b11:   bsh_s = {b_r[W-1], b_r[W-1:1]};
            default: bsh_s = b_r;
        endcase
        bin_s = bsel_r ? sximm5_r : bsh_s;
        alu_s = {W{1'b0}};
        ovf_s = 1'b0;
        case (aluop_r)
            2'b00: begin
                alu_s = ain_s + bin_s;
                ovf_s = (ain_s[W-1] == bin_s[W-1]) && (alu_s[W-1] != ain_s[W-1]);
            end
            2'b01: begin
                alu_s = ain_s - bin_s;
                ovf_s = (ain_s[W-1] != bin_s[W-1]) && (alu_s[W-1] != ain_s[W-1]);
            end
            2'b10:   alu_s = ain_s & bin_s;
            2'b11:   alu_s = ~bin_s;
            default: alu_s = {W{1'b0}};
        endcase
    end

    // Writeback source select; mdata and PC are taken live during WB.
    always_comb begin
        pc_ext_s = {W{1'b0}};
        pc_ext_s[PCW-1:0] = bus.PC;
        case (vsel_r)
            4'b1000: wb_data_s = bus.mdata;
            4'b0100: wb_data_s = sximm8_r;
            4'b0010: wb_data_s = pc_ext_s;
            4'b0001: wb_data_s = c_r;
            default: wb_data_s = {W{1'b0}};
        endcase
    end

    // Sequencer, register file, operand/result registers and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            for (int i = 0; i < NREG; i++) regs_r[i] <= {W{1'b0}};
            a_r      <= {W{1'b0}};
            b_r      <= {W{1'b0}};
            c_r      <= {W{1'b0}};
            z_r      <= 1'b0;
            v_r      <= 1'b0;
            n_r      <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            rn_r     <= {RW{1'b0}};
            rm_r     <= {RW{1'b0}};
            rd_r     <= {RW{1'b0}};
            shift_r  <= 2'b00;
            aluop_r  <= 2'b00;
            asel_r   <= 1'b0;
            bsel_r   <= 1'b0;
            loads_r  <= 1'b0;
            wb_en_r  <= 1'b0;
            vsel_r   <= 4'b0000;
            sximm8_r <= {W{1'b0}};
            sximm5_r <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        rn_r     <= bus.rn;
                        rm_r     <= bus.rm;
                        rd_r     <= bus.rd;
                        shift_r  <= bus.shift;
                        aluop_r  <= bus.aluop;
                        asel_r   <= bus.asel;
                        bsel_r   <= bus.bsel;
                        loads_r  <= bus.loads;
                        wb_en_r  <= bus.wb_en;
                        vsel_r   <= bus.vsel;
                        sximm8_r <= bus.sximm8;
                        sximm5_r <= bus.sximm5;
                        err_r    <= 1'b0;
                        ready_r  <= 1'b0;
                        state_r  <= ST_LOADA;
                    end
                end
                ST_LOADA: begin
                    a_r     <= regs_r[rn_r];
                    state_r <= ST_LOADB;
                end
                ST_LOADB: begin
                    b_r     <= regs_r[rm_r];
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    c_r <= alu_s;
                    if (loads_r) begin
                        z_r <= (alu_s == {W{1'b0}});
                        v_r <= ovf_s;
                        n_r <= alu_s[W-1];
                    end
                    done_r  <= 1'b1;
                    state_r <= ST_WB;
                end
                ST_WB: begin
                    // An invalid source select suppresses the write but the op still completes.
                    if (wb_en_r) begin
                        if (is_onehot4(vsel_r)) regs_r[rd_r] <= wb_data_s;
                        else                    err_r <= 1'b1;
                    end
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign bus.C     = c_r;
    assign bus.Zout  = z_r;
    assign bus.Vout  = v_r;
    assign bus.Nout  = n_r;
endmodule

// File: tb/tb_datapath_seq.sv
// Directed, table-driven bench for datapath_seq with hand sequences for busy-start,
// back-to-back and mid-operation reset.
module tb_datapath_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    datapath_seq_if #(.W(16), .RW(3), .PCW(8)) bus ();

    datapath_seq #(.W(16), .NREG(8), .RW(3), .PCW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rn, rm, rd;
        logic [1:0]  shift, aluop;
        logic        asel, bsel, loads, wb_en;
        logic [3:0]  vsel;
        logic [15:0] sximm8, sximm5, mdata;
        logic [7:0]  pc;
        logic [15:0] exp_c;
        logic        exp_z, exp_v, exp_n, exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] rn, rm, rd, input logic [1:0] sh, op,
                                input logic as, bs, ld, we, input logic [3:0] vs,
                                input logic [15:0] i8, i5, md, input logic [7:0] pc,
                                input logic [15:0] ec, input logic ez, ev, en, ee);
        vec_t v;
        v.rn = rn; v.rm = rm; v.rd = rd; v.shift = sh; v.aluop = op;
        v.asel = as; v.bsel = bs; v.loads = ld; v.wb_en = we; v.vsel = vs;
        v.sximm8 = i8; v.sximm5 = i5; v.mdata = md; v.pc = pc;
        v.exp_c = ec; v.exp_z = ez; v.exp_v = ev; v.exp_n = en; v.exp_err = ee;
        return v;
    endfunction

    // Read-back op: C = 0 + R[r]; no flag update, no write.
    function automatic vec_t rdreg(input logic [2:0] r, input logic [15:0] ec,
                                   input logic ez, ev, en);
        return mk(3'd0, r, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001,
                  16'h0000, 16'h0000, 16'h0000, 8'h00, ec, ez, ev, en, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.rn = v.rn; bus.rm = v.rm; bus.rd = v.rd; bus.shift = v.shift;
        bus.aluop = v.aluop; bus.asel = v.asel; bus.bsel = v.bsel; bus.loads = v.loads;
        bus.wb_en = v.wb_en; bus.vsel = v.vsel; bus.sximm8 = v.sximm8;
        bus.sximm5 = v.sximm5; bus.mdata = v.mdata; bus.PC = v.pc;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        drive(v);
        chk({tag, ".ready_before"}, {31'd0, bus.ready}, 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
        end
        chk({tag, ".done_latency"}, cyc, 32'd4);
        tick();
        chk({tag, ".ready_after"}, {31'd0, bus.ready}, 32'd1);
        chk({tag, ".done_low"}, {31'd0, bus.done}, 32'd0);
        chk({tag, ".C"}, {16'd0, bus.C}, {16'd0, v.exp_c});
        chk({tag, ".ZVN"}, {29'd0, bus.Zout, bus.Vout, bus.Nout},
            {29'd0, v.exp_z, v.exp_v, v.exp_n});
        chk({tag, ".err"}, {31'd0, bus.err}, {31'd0, v.exp_err});
    endtask

    initial begin
        int pulses;
        int last_done;
        bus.start = 1'b0;
        drive(mk(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000,
                 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));

        //          rn    rm    rd    sh     op     as    bs    ld    we    vsel     sximm8    sximm5    mdata     pc     expC      Z     V     N     err
        vecs.push_back(mk(3'd0, 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 16'h0005, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd0, 3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 16'h0003, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd1, 3'd2, 3'd3, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(rdreg(3'd3, 16'h000B, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd2, 3'd2, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(rdreg(3'd2, 16'h0003, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(3'd0, 3'd0, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 16'h7FFF, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd0, 3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 16'h0000, 16'h0000, 16'h0001, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd1, 3'd2, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(3'd1, 3'd2, 3'd0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd0, 3'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 16'h1234, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
        vecs.push_back(rdreg(3'd4, 16'h0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd0, 3'd0, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 16'h0000, 16'h0000, 16'hFFFF, 8'hA5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(rdreg(3'd5, 16'h00A5, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd0, 3'd2, 3'd0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'd0, 3'd0, 3'd6, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 16'h8000, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'd6, 3'd2, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(3'd0, 3'd6, 3'd0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'hC000, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(3'd0, 3'd6, 3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(3'd2, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 16'h0000, 16'hFFFF, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));

        tick();
        tick();
        chk("reset.ready", {31'd0, bus.ready}, 32'd1);
        chk("reset.done_err", {30'd0, bus.done, bus.err}, 32'd0);
        chk("reset.C", {16'd0, bus.C}, 32'd0);
        chk("reset.ZVN", {29'd0, bus.Zout, bus.Vout, bus.Nout}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // start raised during LOADB, with different fields, must be ignored
        drive(mk(3'd0, 3'd0, 3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 16'h0042, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        drive(mk(3'd0, 3'd0, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 16'h0099, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("busy.done_at_4", {31'd0, bus.done}, 32'd1);
        tick();
        chk("busy.ready_at_5", {31'd0, bus.ready}, 32'd1);
        pulses = 0;
        repeat (6) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        chk("busy.no_extra_done", pulses, 32'd0);
        run_op(rdreg(3'd7, 16'h0042, 1'b1, 1'b0, 1'b0), "busy.R7");
        run_op(rdreg(3'd3, 16'h000B, 1'b1, 1'b0, 1'b0), "busy.R3");

        // start held high: second op accepted the cycle ready returns
        drive(rdreg(3'd5, 16'h0000, 1'b0, 1'b0, 1'b0));
        bus.start = 1'b1;
        pulses = 0;
        last_done = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (bus.done === 1'b1) begin
                pulses++;
                last_done = e;
            end
        end
        bus.start = 1'b0;
        chk("b2b.pulses", pulses, 32'd2);
        chk("b2b.second_done_edge", last_done, 32'd9);
        tick();
        chk("b2b.ready", {31'd0, bus.ready}, 32'd1);
        chk("b2b.C", {16'd0, bus.C}, 32'h0000_00A5);

        // reset during EXEC aborts the writeback and clears all state
        drive(mk(3'd0, 3'd0, 3'd1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 16'h0077, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_exec.ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_exec.done", {31'd0, bus.done}, 32'd0);
        chk("rst_exec.C", {16'd0, bus.C}, 32'd0);
        chk("rst_exec.ZVN", {29'd0, bus.Zout, bus.Vout, bus.Nout}, 32'd0);
        reset = 1'b0;
        tick();
        run_op(rdreg(3'd1, 16'h0000, 1'b0, 1'b0, 1'b0), "rst_exec.R1");
        run_op(rdreg(3'd3, 16'h0000, 1'b0, 1'b0, 1'b0), "rst_exec.R3");
        run_op(rdreg(3'd5, 16'h0000, 1'b0, 1'b0, 1'b0), "rst_exec.R5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
